// File: rtl/ysyx_25020037_ifetch.sv
// Instruction fetch stage: one outstanding memory request, a one-entry output register toward
// decode, redirect handling with a kill flag, and misaligned-PC fault generation.
module ysyx_25020037_ifetch #(
    parameter logic [31:0] RESET_PC = 32'h80000000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        imem_rsp_err,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_inst,
    output logic        out_fault,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] WAIT = 2'd2;
    localparam logic [1:0] OUT  = 2'd3;

    logic [1:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        kill_q, kill_d;
    logic [31:0] kill_pc_q, kill_pc_d;
    logic [31:0] out_pc_q, out_pc_d;
    logic [31:0] out_inst_q, out_inst_d;
    logic        out_fault_q, out_fault_d;
    logic        misaligned;

    // pc_q is the address of the transaction in flight; redirects arriving while a request is
    // outstanding park in kill_pc_q so the request address stays stable until accepted.
    assign misaligned = (pc_q[1:0] != 2'b00);

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        kill_d      = kill_q;
        kill_pc_d   = kill_pc_q;
        out_pc_d    = out_pc_q;
        out_inst_d  = out_inst_q;
        out_fault_d = out_fault_q;
        case (state_q)
            IDLE: state_d = REQ;
            REQ: begin
                if (misaligned) begin
                    // No memory access exists to kill, so a redirect simply replaces the fault.
                    if (redirect_valid) begin
                        pc_d = redirect_pc;
                    end else begin
                        state_d     = OUT;
                        out_pc_d    = pc_q;
                        out_inst_d  = 32'h0;
                        out_fault_d = 1'b1;
                    end
                end else begin
                    if (redirect_valid) begin
                        kill_d    = 1'b1;
                        kill_pc_d = redirect_pc;
                    end
                    if (imem_req_ready) state_d = WAIT;
                end
            end
            WAIT: begin
                if (redirect_valid) begin
                    kill_d    = 1'b1;
                    kill_pc_d = redirect_pc;
                end
                if (imem_rsp_valid) begin
                    if (kill_q || redirect_valid) begin
                        state_d = REQ;
                        kill_d  = 1'b0;
                        pc_d    = redirect_valid ? redirect_pc : kill_pc_q;
                    end else begin
                        state_d     = OUT;
                        out_pc_d    = pc_q;
                        out_inst_d  = imem_rsp_data;
                        out_fault_d = imem_rsp_err;
                    end
                end
            end
            OUT: begin
                if (redirect_valid) begin
                    state_d = REQ;
                    pc_d    = redirect_pc;
                end else if (out_ready) begin
                    state_d = REQ;
                    pc_d    = pc_q + 32'd4;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            pc_q        <= RESET_PC;
            kill_q      <= 1'b0;
            kill_pc_q   <= RESET_PC;
            out_pc_q    <= RESET_PC;
            out_inst_q  <= 32'h0;
            out_fault_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            kill_q      <= kill_d;
            kill_pc_q   <= kill_pc_d;
            out_pc_q    <= out_pc_d;
            out_inst_q  <= out_inst_d;
            out_fault_q <= out_fault_d;
        end
    end

    assign imem_req_valid = (state_q == REQ) && !misaligned;
    assign imem_req_addr  = pc_q;
    assign out_valid      = (state_q == OUT);
    assign out_pc         = out_pc_q;
    assign out_inst       = out_inst_q;
    assign out_fault      = out_fault_q;

endmodule

// File: doc/ysyx_25020037_ifetch.md
YSYX_25020037_IFETCH -- requirements
Module: ysyx_25020037_ifetch

Interface
REQ-001 Parameter RESET_PC, default 32'h80000000, address of the first fetch after reset.
REQ-002 clk  input  1  sole clock, all state on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low (0 = reset asserted).
REQ-004 imem_req_valid  output  1  fetch request valid.
REQ-005 imem_req_ready  input  1  memory accepts the request.
REQ-006 imem_req_addr  output  32  fetch byte address.
REQ-007 imem_rsp_valid  input  1  response valid; the block is always ready for a response.
REQ-008 imem_rsp_data  input  32  fetched instruction word.
REQ-009 imem_rsp_err  input  1  access fault for this response.
REQ-010 out_valid  output  1  instruction valid toward decode.
REQ-011 out_ready  input  1  decode accepts the instruction.
REQ-012 out_pc  output  32  PC of out_inst.
REQ-013 out_inst  output  32  instruction word.
REQ-014 out_fault  output  1  instruction carries fetch fault (access or misaligned).
REQ-015 redirect_valid  input  1  one-cycle control-flow redirect from execute.
REQ-016 redirect_pc  input  32  redirect target.

Function
REQ-017 The block SHALL implement the FSM IDLE, REQ, WAIT, OUT; IDLE is entered only on reset and SHALL go to REQ on the first clock after reset deasserts.
REQ-018 Handshakes complete on a rising edge with valid and ready both 1; one request outstanding at most.
REQ-019 REQ: imem_req_valid=1 and imem_req_addr=latched fetch address; both SHALL stay stable until imem_req_ready; on acceptance go WAIT.
REQ-020 WAIT: on imem_rsp_valid, capture data, err and PC into the output register, go OUT; imem_rsp_valid outside WAIT SHALL be ignored.
REQ-021 OUT: out_valid=1; out_pc/out_inst/out_fault stable until out_ready; on acceptance pc <= pc+4 (mod 2^32, 32'hFFFFFFFC wraps to 0) and go REQ.
REQ-022 Latency: with ready memory and 1-cycle response, consecutive instructions SHALL appear every 3 cycles (REQ, WAIT, OUT).
REQ-023 Redirect in OUT without same-cycle out handshake: buffered instruction discarded, out_valid=0 next cycle, pc <= redirect_pc, go REQ.
REQ-024 Redirect in OUT with same-cycle out handshake: instruction delivered, pc <= redirect_pc (not pc+4), go REQ.
REQ-025 Redirect in REQ or WAIT: pc <= redirect_pc, kill flag set; outstanding request still completes per REQ-019/020 but its response SHALL be dropped (no OUT), then go REQ with the new pc and clear kill.
REQ-026 Repeated redirects while kill is set: last redirect_pc wins, single kill, only one response dropped.
REQ-027 If the fetch address has bits[1:0]!=0, no memory request SHALL be issued; the block SHALL go from REQ directly to OUT with out_fault=1, out_inst=0, out_pc=that address.
REQ-028 imem_rsp_err=1 SHALL give out_fault=1 with out_inst=imem_rsp_data; fetch continues normally at pc+4 unless redirected.
REQ-029 The next PC on instruction acceptance SHALL be pc+4 irrespective of out_fault.

Reset
REQ-030 While rst=0: state IDLE, pc=RESET_PC, kill=0, imem_req_valid=0, imem_req_addr=RESET_PC, out_valid=0, out_pc=RESET_PC, out_inst=0, out_fault=0.
REQ-031 Reset asserted mid-transaction SHALL abandon it immediately; a late imem_rsp_valid after reset deasserts, before the new request is accepted, SHALL be ignored.

Verification
REQ-032 Reset release, memory always ready, 1-cycle response, out_ready=1 -> requests at 0x80000000, 0x80000004, 0x80000008, one out_valid per 3 cycles with matching out_pc/out_inst.
REQ-033 imem_req_ready held 0 for 4 cycles -> imem_req_valid=1 and addr 0x80000000 constant all 4 cycles; out_ready held 0 for 5 cycles -> outputs constant, no new request.
REQ-034 Redirect to 0x80000100 in WAIT -> pending response dropped, next request addr 0x80000100, first out_pc 0x80000100.
REQ-035 Redirect to 0x80000200 in OUT with out_ready=1 same cycle -> current instruction delivered once, next request addr 0x80000200; with out_ready=0 -> not delivered.
REQ-036 Redirect to 0x80000102 -> no request issued, out_valid with out_fault=1, out_inst=0, out_pc=0x80000102; imem_rsp_err=1 on a normal fetch -> out_fault=1, next fetch pc+4.
REQ-037 rst pulsed low during WAIT, stale imem_rsp_valid one cycle after release -> ignored, fresh fetch from 0x80000000.
